cache_refill_ctrl: RTL and testbench

Miss-handling engine on the AXI side of a cached port: the responder to the tag array's `miss` / `write_back` request. On a miss it optionally writes the victim line back as a 16-beat INCR burst, fetches the missing line as a 16-beat INCR burst into a line buffer, then pulses `refresh` so the tag and data arrays install the line. It sits between the tag/data arrays and the AXI crossbar; one outstanding miss at a time.

---
 rtl/cache_pkg.sv | 24 ++
 rtl/cache_line_buf.sv | 31 +++
 rtl/cache_refill_ctrl.sv | 171 +++++++++++++++++
 tb/tb_cache_refill_ctrl.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// Shared constants and state encoding for the cache miss/refill engine.
package cache_pkg;

    localparam int LINE_WORDS = 16;
    localparam int WORD_W     = 32;
    localparam int LINE_W     = LINE_WORDS * WORD_W;
    localparam int CNT_W      = $clog2(LINE_WORDS);

    localparam logic [CNT_W-1:0] LAST_BEAT  = CNT_W'(LINE_WORDS - 1);
    localparam logic [7:0]       BURST_LEN  = 8'(LINE_WORDS - 1);
    localparam logic [1:0]       BURST_INCR = 2'b01;
    localparam logic [2:0]       SIZE_4B    = 3'b010;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_AW,
        ST_W,
        ST_B,
        ST_AR,
        ST_R,
        ST_REFRESH
    } state_t;

endpackage

// File: rtl/cache_line_buf.sv
// One-line buffer shared by the victim drain and the refill fill:
// parallel load, per-word write/read at idx, flat line output.
module cache_line_buf
    import cache_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [LINE_W-1:0] load_line,
    input  logic              wr_en,
    input  logic [CNT_W-1:0]  idx,
    input  logic [WORD_W-1:0] wr_data,
    output logic [WORD_W-1:0] rd_data,
    output logic [LINE_W-1:0] line
);

    logic [LINE_WORDS-1:0][WORD_W-1:0] mem;

    always_ff @(posedge clk) begin
        if (rst)
            mem <= '0;
        else if (load)
            mem <= load_line;
        else if (wr_en)
            mem[idx] <= wr_data;
    end

    assign rd_data = mem[idx];
    assign line    = mem;

endmodule

// File: rtl/cache_refill_ctrl.sv
// AXI miss engine: optional victim writeback burst, then line refill burst
// and a one-cycle install pulse. Writeback path present only with CACHE_WB_EN.
module cache_refill_ctrl
    import cache_pkg::*;
#(
    parameter logic [3:0] AXI_ID = 4'd0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         miss,
    input  logic         write_back,
    input  logic [31:0]  axi_raddr,
    input  logic [31:0]  axi_waddr,
    input  logic [511:0] victim_line,
    output logic         busy,
    output logic         refresh,
    output logic [511:0] refill_line,
    output logic [3:0]   arid,
    output logic [31:0]  araddr,
    output logic [7:0]   arlen,
    output logic [2:0]   arsize,
    output logic [1:0]   arburst,
    output logic         arvalid,
    input  logic         arready,
    input  logic [31:0]  rdata,
    input  logic         rlast,
    input  logic         rvalid,
    output logic         rready,
    output logic [3:0]   awid,
    output logic [31:0]  awaddr,
    output logic [7:0]   awlen,
    output logic [2:0]   awsize,
    output logic [1:0]   awburst,
    output logic         awvalid,
    input  logic         awready,
    output logic [31:0]  wdata,
    output logic [3:0]   wstrb,
    output logic         wlast,
    output logic         wvalid,
    input  logic         wready,
    input  logic         bvalid,
    output logic         bready
);

    state_t             state, nxt;
    logic [CNT_W-1:0]   cnt;
    logic [31:0]        raddr_q;
    logic [WORD_W-1:0]  buf_word;
    logic               buf_load;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            raddr_q <= '0;
        end else begin
            state <= nxt;
            case (state)
                ST_IDLE: begin
                    cnt <= '0;
                    if (miss) raddr_q <= axi_raddr;
                end
`ifdef CACHE_WB_EN
                ST_W:    if (wready) cnt <= cnt + 1'b1;
`endif
                ST_R:    if (rvalid) cnt <= cnt + 1'b1;
                default: ;
            endcase
        end
    end

    always_comb begin
        nxt     = state;
        arvalid = 1'b0;
        rready  = 1'b0;
        refresh = 1'b0;
        awvalid = 1'b0;
        wvalid  = 1'b0;
        bready  = 1'b0;
        case (state)
            ST_IDLE: begin
`ifdef CACHE_WB_EN
                if (miss) nxt = write_back ? ST_AW : ST_AR;
`else
                if (miss) nxt = ST_AR;
`endif
            end
`ifdef CACHE_WB_EN
            ST_AW: begin
                awvalid = 1'b1;
                if (awready) nxt = ST_W;
            end
            ST_W: begin
                wvalid = 1'b1;
                if (wready && cnt == LAST_BEAT) nxt = ST_B;
            end
            ST_B: begin
                bready = 1'b1;
                if (bvalid) nxt = ST_AR;
            end
`endif
            ST_AR: begin
                arvalid = 1'b1;
                if (arready) nxt = ST_R;
            end
            ST_R: begin
                rready = 1'b1;
                // the slave's rlast ends the burst, not our own count
                if (rvalid && rlast) nxt = ST_REFRESH;
            end
            ST_REFRESH: begin
                refresh = 1'b1;
                nxt     = ST_IDLE;
            end
            default: nxt = ST_IDLE;
        endcase
    end

    assign busy    = (state != ST_IDLE);
    assign arid    = AXI_ID;
    assign araddr  = raddr_q;
    assign arlen   = BURST_LEN;
    assign arsize  = SIZE_4B;
    assign arburst = BURST_INCR;

`ifdef CACHE_WB_EN
    logic [31:0] waddr_q;

    always_ff @(posedge clk) begin
        if (rst)
            waddr_q <= '0;
        else if (state == ST_IDLE && miss)
            waddr_q <= axi_waddr;
    end

    assign buf_load = (state == ST_IDLE) && miss && write_back;
    assign awid     = AXI_ID;
    assign awaddr   = waddr_q;
    assign awlen    = BURST_LEN;
    assign awsize   = SIZE_4B;
    assign awburst  = BURST_INCR;
    assign wdata    = buf_word;
    assign wstrb    = 4'hF;
    assign wlast    = wvalid && (cnt == LAST_BEAT);
`else
    logic unused_wb;
    assign unused_wb = ^{write_back, axi_waddr, victim_line, awready, wready, bvalid, buf_word};
    assign buf_load  = 1'b0;
    assign awid      = '0;
    assign awaddr    = '0;
    assign awlen     = '0;
    assign awsize    = '0;
    assign awburst   = '0;
    assign wdata     = '0;
    assign wstrb     = '0;
    assign wlast     = 1'b0;
`endif

    cache_line_buf u_buf (
        .clk       (clk),
        .rst       (rst),
        .load      (buf_load),
        .load_line (victim_line),
        .wr_en     ((state == ST_R) && rvalid),
        .idx       (cnt),
        .wr_data   (rdata),
        .rd_data   (buf_word),
        .line      (refill_line)
    );

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// Bench for cache_refill_ctrl: AXI slave/monitor process plus scenario tasks.
module tb_cache_refill_ctrl;

    logic         clk = 1'b0;
    logic         rst, miss, write_back;
    logic [31:0]  axi_raddr, axi_waddr;
    logic [511:0] victim_line;
    logic         busy, refresh;
    logic [511:0] refill_line;
    logic [3:0]   arid, awid;
    logic [31:0]  araddr, awaddr, rdata, wdata;
    logic [7:0]   arlen, awlen;
    logic [2:0]   arsize, awsize;
    logic [1:0]   arburst, awburst;
    logic         arvalid, arready, rlast, rvalid, rready;
    logic         awvalid, awready, wlast, wvalid, wready, bvalid, bready;
    logic [3:0]   wstrb;

    always #5 clk = ~clk;

    cache_refill_ctrl dut (
        .clk(clk), .rst(rst), .miss(miss), .write_back(write_back),
        .axi_raddr(axi_raddr), .axi_waddr(axi_waddr), .victim_line(victim_line),
        .busy(busy), .refresh(refresh), .refill_line(refill_line),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
        .arburst(arburst), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
        .awburst(awburst), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid),
        .wready(wready), .bvalid(bvalid), .bready(bready)
    );

    int checks = 0, errors = 0;

    // slave memory image and transaction logs
    bit          stall_en;
    logic [31:0] rd_line [16];
    logic [31:0] vic     [16];
    bit          rd_active, b_pend, b_done;
    int          rd_beat;
    int          ar_cnt, aw_cnt, refresh_cnt, order_viol, stab_viol, wr_side_seen, wstrb_bad;
    logic [31:0] ar_addr_last, aw_addr_last;
    logic [7:0]  ar_len_last, aw_len_last;
    logic [2:0]  ar_size_last;
    logic [1:0]  ar_burst_last;
    logic [3:0]  ar_id_last;
    logic [31:0] w_data_q[$];
    logic        w_last_q[$];
    logic [511:0] refresh_line;
    bit          ar_wait, aw_wait, w_wait;
    logic [31:0] ar_wait_addr, aw_wait_addr, w_wait_data;
    logic        w_wait_last;

    function automatic logic [511:0] pack_rd();
        logic [511:0] l;
        for (int i = 0; i < 16; i++) l[32*i +: 32] = rd_line[i];
        return l;
    endfunction

    function automatic logic [511:0] pack_vic();
        logic [511:0] l;
        for (int i = 0; i < 16; i++) l[32*i +: 32] = vic[i];
        return l;
    endfunction

    task automatic clear_logs();
        ar_cnt = 0; aw_cnt = 0; refresh_cnt = 0; order_viol = 0; stab_viol = 0;
        wr_side_seen = 0; wstrb_bad = 0; b_done = 0;
        w_data_q.delete(); w_last_q.delete();
        refresh_line = '0;
    endtask

    // AXI slave + protocol monitor; decisions made on negedge, DUT outputs are stable then
    initial begin
        arready = 0; rvalid = 0; rlast = 0; rdata = 0; awready = 0; wready = 0; bvalid = 0;
        rd_active = 0; b_pend = 0; rd_beat = 0;
        ar_wait = 0; aw_wait = 0; w_wait = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                arready = 0; rvalid = 0; rlast = 0; awready = 0; wready = 0; bvalid = 0;
                rd_active = 0; b_pend = 0; rd_beat = 0;
                ar_wait = 0; aw_wait = 0; w_wait = 0;
            end else begin
                if (ar_wait && (arvalid !== 1'b1 || araddr !== ar_wait_addr)) stab_viol++;
                if (aw_wait && (awvalid !== 1'b1 || awaddr !== aw_wait_addr)) stab_viol++;
                if (w_wait && (wvalid !== 1'b1 || wdata !== w_wait_data || wlast !== w_wait_last)) stab_viol++;
                if (refresh) begin refresh_cnt++; refresh_line = refill_line; end
                if (awvalid || wvalid || bready) wr_side_seen++;

                arready = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
                awready = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
                wready  = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;

                rvalid = 0; rlast = 0; rdata = $urandom;
                if (rd_active) begin
                    rvalid = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
                    rdata  = rd_line[rd_beat];
                    rlast  = (rd_beat == 15);
                    if (rvalid && rready) begin
                        if (rd_beat == 15) rd_active = 0;
                        rd_beat++;
                    end
                end

                bvalid = 0;
                if (b_pend) begin
                    bvalid = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
                    if (bvalid && bready) begin b_pend = 0; b_done = 1; end
                end

                if (arvalid && arready) begin
                    ar_cnt++;
                    ar_addr_last = araddr; ar_len_last = arlen; ar_size_last = arsize;
                    ar_burst_last = arburst; ar_id_last = arid;
                    if (aw_cnt > 0 && !b_done) order_viol++;
                    rd_active = 1; rd_beat = 0;
                end
                if (awvalid && awready) begin
                    aw_cnt++; aw_addr_last = awaddr; aw_len_last = awlen;
                end
                if (wvalid && wready) begin
                    w_data_q.push_back(wdata); w_last_q.push_back(wlast);
                    if (wstrb !== 4'hF) wstrb_bad++;
                    if (wlast) b_pend = 1;
                end

                ar_wait = arvalid && !arready; ar_wait_addr = araddr;
                aw_wait = awvalid && !awready; aw_wait_addr = awaddr;
                w_wait  = wvalid && !wready;   w_wait_data = wdata; w_wait_last = wlast;
            end
        end
    end

    // cyc counts the cycle in which miss is first presented as cycle 1
    task automatic run_miss(input logic [31:0] ra, input logic [31:0] wa, input bit wb,
                            output int cyc, output bit timeout);
        @(negedge clk);
        axi_raddr = ra; axi_waddr = wa; write_back = wb; victim_line = pack_vic();
        miss = 1; cyc = 1; timeout = 1;
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk); #1;
            cyc++;
            if (refresh) begin timeout = 0; break; end
        end
        miss = 0; write_back = 0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1; miss = 0; write_back = 0; axi_raddr = 0; axi_waddr = 0; victim_line = '0;
        stall_en = 0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if ({arvalid, rready, awvalid, wvalid, bready, refresh} !== 6'b0) begin
            errors++; $display("FAIL reset_valids: got %b expected 000000", {arvalid, rready, awvalid, wvalid, bready, refresh}); end
        checks++; if (refill_line !== 512'b0) begin errors++; $display("FAIL reset_refill_line: got %h expected 0", refill_line); end
        checks++; if (araddr !== 32'h0) begin errors++; $display("FAIL reset_araddr: got %h expected 0", araddr); end
        rst = 0;
        @(posedge clk); #1;
        clear_logs();
    endtask

    task automatic test_clean_miss();
        int cyc; bit to;
        stall_en = 0; clear_logs();
        for (int i = 0; i < 16; i++) begin rd_line[i] = 32'hA000_0000 + i; vic[i] = 0; end
        run_miss(32'h1FC0_0040, 32'h0, 1'b0, cyc, to);
        checks++; if (to || cyc != 19) begin errors++; $display("FAIL clean_latency: got cycle %0d (timeout %0d) expected 19", cyc, to); end
        checks++; if (ar_cnt != 1) begin errors++; $display("FAIL clean_ar_count: got %0d expected 1", ar_cnt); end
        checks++; if ({ar_addr_last, ar_len_last, ar_size_last, ar_burst_last, ar_id_last} !== {32'h1FC0_0040, 8'd15, 3'd2, 2'b01, 4'd0}) begin
            errors++; $display("FAIL clean_ar_fields: got addr %h len %0d size %0d burst %b id %0d expected 1fc00040 15 2 01 0",
                                ar_addr_last, ar_len_last, ar_size_last, ar_burst_last, ar_id_last); end
        checks++; if (refresh_line[511:480] !== 32'hA000_000F) begin errors++; $display("FAIL clean_word15: got %h expected a000000f", refresh_line[511:480]); end
        checks++; if (refresh_line !== pack_rd()) begin errors++; $display("FAIL clean_line: got %h expected %h", refresh_line, pack_rd()); end
        checks++; if (refresh_cnt != 1 || busy !== 1'b0) begin errors++; $display("FAIL clean_single_refresh: got %0d pulses busy %b expected 1 pulse busy 0", refresh_cnt, busy); end
        checks++; if (aw_cnt != 0 || wr_side_seen != 0) begin errors++; $display("FAIL clean_no_write: got aw %0d wr-side cycles %0d expected 0 0", aw_cnt, wr_side_seen); end
    endtask

`ifdef CACHE_WB_EN
    task automatic test_dirty_miss();
        int cyc; bit to; bit last_ok;
        stall_en = 0; clear_logs();
        for (int i = 0; i < 16; i++) begin rd_line[i] = 32'h5500_0000 + i; vic[i] = i; end
        run_miss(32'h0000_2000, 32'h0000_1000, 1'b1, cyc, to);
        checks++; if (to || cyc != 37) begin errors++; $display("FAIL dirty_latency: got cycle %0d (timeout %0d) expected 37", cyc, to); end
        checks++; if (aw_cnt != 1 || aw_addr_last !== 32'h1000 || aw_len_last !== 8'd15) begin
            errors++; $display("FAIL dirty_aw: got count %0d addr %h len %0d expected 1 1000 15", aw_cnt, aw_addr_last, aw_len_last); end
        checks++; if (w_data_q.size() != 16) begin errors++; $display("FAIL dirty_w_beats: got %0d expected 16", w_data_q.size()); end
        else begin
            for (int i = 0; i < 16; i++) begin
                checks++; if (w_data_q[i] !== 32'(i)) begin errors++; $display("FAIL dirty_wdata[%0d]: got %h expected %h", i, w_data_q[i], i); end
            end
            last_ok = 1;
            for (int i = 0; i < 16; i++) if (w_last_q[i] !== (i == 15)) last_ok = 0;
            checks++; if (!last_ok) begin errors++; $display("FAIL dirty_wlast: got misplaced wlast expected beat 15 only"); end
        end
        checks++; if (wstrb_bad != 0) begin errors++; $display("FAIL dirty_wstrb: got %0d bad beats expected 0", wstrb_bad); end
        checks++; if (ar_cnt != 1 || order_viol != 0) begin errors++; $display("FAIL dirty_ar_after_b: got ar %0d early %0d expected 1 0", ar_cnt, order_viol); end
        checks++; if (refresh_line !== pack_rd()) begin errors++; $display("FAIL dirty_line: got %h expected %h", refresh_line, pack_rd()); end
    endtask
`else
    task automatic test_no_wb();
        int cyc; bit to;
        stall_en = 0; clear_logs();
        for (int i = 0; i < 16; i++) begin rd_line[i] = $urandom; vic[i] = 32'hDEAD_0000 + i; end
        run_miss(32'h0000_3000, 32'h0000_1000, 1'b1, cyc, to);
        checks++; if (to || cyc != 19) begin errors++; $display("FAIL nowb_latency: got cycle %0d (timeout %0d) expected 19", cyc, to); end
        checks++; if (aw_cnt != 0 || wr_side_seen != 0) begin errors++; $display("FAIL nowb_no_write: got aw %0d wr-side cycles %0d expected 0 0", aw_cnt, wr_side_seen); end
        checks++; if (ar_cnt != 1 || ar_addr_last !== 32'h3000) begin errors++; $display("FAIL nowb_ar: got count %0d addr %h expected 1 3000", ar_cnt, ar_addr_last); end
        checks++; if (refresh_line !== pack_rd()) begin errors++; $display("FAIL nowb_line: got %h expected %h", refresh_line, pack_rd()); end
    endtask
`endif

    task automatic test_random_stalls();
        int cyc; bit to; bit wb; int wbad; logic [31:0] ra, wa;
        for (int it = 0; it < 8; it++) begin
            stall_en = 1; clear_logs();
            ra = $urandom & 32'hFFFF_FFC0; wa = $urandom & 32'hFFFF_FFC0; wb = 1'($urandom_range(0, 1));
            for (int i = 0; i < 16; i++) begin rd_line[i] = $urandom; vic[i] = $urandom; end
            run_miss(ra, wa, wb, cyc, to);
            checks++; if (to) begin errors++; $display("FAIL stall_timeout[%0d]: got no refresh expected refresh", it); end
            checks++; if (refresh_line !== pack_rd()) begin errors++; $display("FAIL stall_line[%0d]: got %h expected %h", it, refresh_line, pack_rd()); end
            checks++; if (stab_viol != 0) begin errors++; $display("FAIL stall_stability[%0d]: got %0d violations expected 0", it, stab_viol); end
            checks++; if (ar_cnt != 1 || ar_addr_last !== ra || refresh_cnt != 1) begin
                errors++; $display("FAIL stall_ar[%0d]: got ar %0d addr %h refresh %0d expected 1 %h 1", it, ar_cnt, ar_addr_last, refresh_cnt, ra); end
`ifdef CACHE_WB_EN
            wbad = 0;
            if (wb) begin
                if (w_data_q.size() != 16) wbad = 1;
                else for (int i = 0; i < 16; i++) if (w_data_q[i] !== vic[i]) wbad = 1;
            end else if (w_data_q.size() != 0) wbad = 1;
            checks++; if (wbad != 0 || aw_cnt != int'(wb) || order_viol != 0) begin
                errors++; $display("FAIL stall_wb[%0d]: got aw %0d beats %0d early-ar %0d expected aw %0d matching victim", it, aw_cnt, w_data_q.size(), order_viol, wb); end
`else
            wbad = 0;
            checks++; if (aw_cnt != wbad || wr_side_seen != 0) begin errors++; $display("FAIL stall_nowb[%0d]: got aw %0d expected 0", it, aw_cnt); end
`endif
        end
        stall_en = 0;
    endtask

    task automatic test_flush_drop();
        bit to;
        stall_en = 0; clear_logs();
        for (int i = 0; i < 16; i++) rd_line[i] = $urandom;
        @(negedge clk);
        axi_raddr = 32'h0000_8000; write_back = 0; miss = 1; to = 1;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk); #1;
            if (rd_active && rd_beat >= 4) begin to = 0; break; end
        end
        miss = 0;
        checks++; if (to) begin errors++; $display("FAIL flush_reach_r: got no read beats expected beats"); end
        repeat (60) @(posedge clk);
        #1;
        checks++; if (refresh_cnt != 1 || ar_cnt != 1) begin errors++; $display("FAIL flush_complete: got refresh %0d ar %0d expected 1 1", refresh_cnt, ar_cnt); end
        checks++; if (refresh_line !== pack_rd()) begin errors++; $display("FAIL flush_line: got %h expected %h", refresh_line, pack_rd()); end
    endtask

    task automatic test_reset_mid_burst();
        bit to; int cyc;
        stall_en = 0; clear_logs();
        for (int i = 0; i < 16; i++) begin rd_line[i] = 32'h7700_0000 + i; vic[i] = 32'h3300_0000 + i; end
        @(negedge clk);
        axi_raddr = 32'h0000_4000; axi_waddr = 32'h0000_5000; victim_line = pack_vic();
        write_back = 1; miss = 1; to = 1;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk); #1;
`ifdef CACHE_WB_EN
            if (w_data_q.size() == 7) begin to = 0; break; end
`else
            if (rd_active && rd_beat == 7) begin to = 0; break; end
`endif
        end
        checks++; if (to) begin errors++; $display("FAIL rstmid_reach_beat7: got timeout expected beat 7"); end
        rst = 1; miss = 0; write_back = 0;
        @(posedge clk); #1;
        checks++; if ({busy, arvalid, rready, awvalid, wvalid, bready, refresh} !== 7'b0) begin
            errors++; $display("FAIL rstmid_outputs: got %b expected 0000000", {busy, arvalid, rready, awvalid, wvalid, bready, refresh}); end
        checks++; if (refill_line !== 512'b0) begin errors++; $display("FAIL rstmid_line: got %h expected 0", refill_line); end
        rst = 0;
        @(posedge clk); #1;
        clear_logs();
        for (int i = 0; i < 16; i++) begin rd_line[i] = 32'h9900_0000 + i; vic[i] = 32'h4400_0000 + i; end
        run_miss(32'h0000_4000, 32'h0000_5000, 1'b1, cyc, to);
`ifdef CACHE_WB_EN
        checks++; if (to || cyc != 37) begin errors++; $display("FAIL rstmid_retry_latency: got cycle %0d expected 37", cyc); end
        checks++; if (w_data_q.size() != 16 || w_data_q[0] !== vic[0] || w_data_q[15] !== vic[15]) begin
            errors++; $display("FAIL rstmid_retry_w: got %0d beats expected 16 from beat 0"); end
`else
        checks++; if (to || cyc != 19) begin errors++; $display("FAIL rstmid_retry_latency: got cycle %0d expected 19", cyc); end
`endif
        checks++; if (refresh_line !== pack_rd() || ar_cnt != 1) begin errors++; $display("FAIL rstmid_retry_line: got %h ar %0d expected %h 1", refresh_line, ar_cnt, pack_rd()); end
    endtask

    initial begin
        test_reset();
        test_clean_miss();
`ifdef CACHE_WB_EN
        test_dirty_miss();
`else
        test_no_wb();
`endif
        test_random_stalls();
        test_flush_drop();
        test_reset_mid_burst();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
